// File: rtl/pdp8_tt_uart.sv
// PDP-8 teletype-style 8N1 UART: fixed-rate transmitter plus a 16x oversampled receiver
// with keyboard-flag style handshake (rx_ready / rx_ack) and sticky overrun/framing errors.
module pdp8_tt_uart #(
    parameter int unsigned BAUD_DIV = 326
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       txd,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    input  logic       rx_ack,
    output logic       rx_overrun,
    output logic       rx_frame_err
);
    localparam int unsigned BIT_CLKS = 16 * BAUD_DIV;
    localparam int unsigned BIT_CW   = $clog2(BIT_CLKS);
    localparam int unsigned BAUD_CW  = $clog2(BAUD_DIV);
    localparam logic [BIT_CW-1:0]  BIT_LAST  = BIT_CW'(BIT_CLKS - 1);
    localparam logic [BAUD_CW-1:0] BAUD_LAST = BAUD_CW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

    tx_state_t         tx_state_q, tx_state_d;
    logic [BIT_CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]        tx_bit_q, tx_bit_d;
    logic [7:0]        tx_shift_q, tx_shift_d;
    logic              txd_q, txd_d;
    logic              tx_busy_q, tx_busy_d;
    logic              tx_done_q, tx_done_d;

    logic               rx_sync1_q, rx_sync2_q;
    logic [BAUD_CW-1:0] baud_cnt_q, baud_cnt_d;
    logic               rx_tick;
    rx_state_t          rx_state_q, rx_state_d;
    logic [3:0]         rx_tick_cnt_q, rx_tick_cnt_d;
    logic [2:0]         rx_bit_q, rx_bit_d;
    logic [7:0]         rx_shift_q, rx_shift_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               rx_ready_q, rx_ready_d;
    logic               rx_overrun_q, rx_overrun_d;
    logic               rx_frame_err_q, rx_frame_err_d;
    logic               rx_done, rx_err;

    assign tx_busy      = tx_busy_q;
    assign tx_done      = tx_done_q;
    assign txd          = txd_q;
    assign rx_data      = rx_data_q;
    assign rx_ready     = rx_ready_q;
    assign rx_overrun   = rx_overrun_q;
    assign rx_frame_err = rx_frame_err_q;

    // Transmitter times its bits directly in clocks; the oversample tick belongs to RX only.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        tx_busy_d  = tx_busy_q;
        tx_done_d  = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_start) begin
                    tx_shift_d = tx_data;
                    tx_state_d = TX_START;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    txd_d      = 1'b0;
                    tx_busy_d  = 1'b1;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_DATA;
                    txd_d      = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        txd_d      = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                    tx_busy_d  = 1'b0;
                    tx_done_d  = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign rx_tick = (baud_cnt_q == BAUD_LAST);

    always_comb begin
        baud_cnt_d     = rx_tick ? '0 : baud_cnt_q + 1'b1;
        rx_state_d     = rx_state_q;
        rx_tick_cnt_d  = rx_tick_cnt_q;
        rx_bit_d       = rx_bit_q;
        rx_shift_d     = rx_shift_q;
        rx_data_d      = rx_data_q;
        rx_ready_d     = rx_ready_q;
        rx_overrun_d   = rx_overrun_q;
        rx_frame_err_d = rx_frame_err_q;
        rx_done        = 1'b0;
        rx_err         = 1'b0;
        if (rx_tick) begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (!rx_sync2_q) begin
                        rx_state_d    = RX_START;
                        rx_tick_cnt_d = '0;
                    end
                end
                RX_START: begin
                    if (rx_tick_cnt_q == 4'd7) begin
                        rx_tick_cnt_d = '0;
                        rx_bit_d      = '0;
                        rx_state_d    = rx_sync2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_tick_cnt_d = rx_tick_cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_tick_cnt_q == 4'd15) begin
                        rx_tick_cnt_d = '0;
                        rx_shift_d    = {rx_sync2_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                        else                  rx_bit_d   = rx_bit_q + 1'b1;
                    end else begin
                        rx_tick_cnt_d = rx_tick_cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_tick_cnt_q == 4'd15) begin
                        rx_tick_cnt_d = '0;
                        if (rx_sync2_q) begin
                            rx_state_d = RX_IDLE;
                            rx_done    = 1'b1;
                        end else begin
                            rx_state_d = RX_BREAK;
                            rx_err     = 1'b1;
                        end
                    end else begin
                        rx_tick_cnt_d = rx_tick_cnt_q + 1'b1;
                    end
                end
                RX_BREAK: if (rx_sync2_q) rx_state_d = RX_IDLE;
                default:  rx_state_d = RX_IDLE;
            endcase
        end
        // Acknowledge clears first so a character completing in the same cycle loads cleanly.
        if (rx_ack) begin
            rx_ready_d     = 1'b0;
            rx_overrun_d   = 1'b0;
            rx_frame_err_d = 1'b0;
        end
        if (rx_err) rx_frame_err_d = 1'b1;
        if (rx_done) begin
            if (!rx_ready_d) begin
                rx_data_d  = rx_shift_d;
                rx_ready_d = 1'b1;
            end else begin
                rx_overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync1_q     <= 1'b1;
            rx_sync2_q     <= 1'b1;
            baud_cnt_q     <= '0;
            rx_state_q     <= RX_IDLE;
            rx_tick_cnt_q  <= '0;
            rx_bit_q       <= '0;
            rx_shift_q     <= '0;
            rx_data_q      <= '0;
            rx_ready_q     <= 1'b0;
            rx_overrun_q   <= 1'b0;
            rx_frame_err_q <= 1'b0;
        end else begin
            rx_sync1_q     <= rxd;
            rx_sync2_q     <= rx_sync1_q;
            baud_cnt_q     <= baud_cnt_d;
            rx_state_q     <= rx_state_d;
            rx_tick_cnt_q  <= rx_tick_cnt_d;
            rx_bit_q       <= rx_bit_d;
            rx_shift_q     <= rx_shift_d;
            rx_data_q      <= rx_data_d;
            rx_ready_q     <= rx_ready_d;
            rx_overrun_q   <= rx_overrun_d;
            rx_frame_err_q <= rx_frame_err_d;
        end
    end
endmodule

// File: tb/tb_pdp8_tt_uart.sv
// Bench for pdp8_tt_uart at BAUD_DIV=2: frame-level model checked every cycle plus directed literals.
module tb_pdp8_tt_uart;
    localparam int B     = 2;
    localparam int BIT   = 16 * B;
    localparam int FRAME = 10 * BIT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, txd;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_ack = 1'b0;
    logic       rx_overrun, rx_frame_err;

    int nchk = 0;
    int nerr = 0;
    bit chk_en = 0;

    // Model state: cycle count, TX frame under way, RX flag register, one pending RX completion.
    int         cyc = 0;
    int         m_rel = 0;
    bit         m_act = 0;
    int         m_acc = 0;
    logic [9:0] m_frame = '1;
    logic [7:0] m_rxd = 8'h00;
    bit         m_rdy = 0, m_ovr = 0, m_ferr = 0;
    bit         ev_pend = 0, ev_ok = 0;
    int         ev_edge = 0;
    logic [7:0] ev_val = 8'h00;

    logic e_txd, e_busy, e_done;
    int   k;
    int   acc, done_n, done_cnt;
    bit   got;

    pdp8_tt_uart #(.BAUD_DIV(B)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .tx_done(tx_done), .txd(txd), .rxd(rxd),
        .rx_data(rx_data), .rx_ready(rx_ready), .rx_ack(rx_ack),
        .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            m_act = 0; m_rdy = 0; m_ovr = 0; m_ferr = 0; m_rxd = 8'h00;
            ev_pend = 0; m_rel = cyc;
        end else begin
            if (tx_start && !(m_act && (cyc - 1 - m_acc) < FRAME)) begin
                m_act = 1; m_acc = cyc; m_frame = {1'b1, tx_data, 1'b0};
            end
            if (rx_ack) begin m_rdy = 0; m_ovr = 0; m_ferr = 0; end
            if (ev_pend && cyc == ev_edge) begin
                ev_pend = 0;
                if (!ev_ok)      m_ferr = 1;
                else if (!m_rdy) begin m_rdy = 1; m_rxd = ev_val; end
                else             m_ovr = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            e_txd = 1'b1; e_busy = 1'b0; e_done = 1'b0;
            if (!reset && m_act) begin
                k = cyc - m_acc;
                if (k < FRAME) begin e_txd = m_frame[k / BIT]; e_busy = 1'b1; end
                e_done = (k == FRAME);
            end
            chk("txd", 32'(txd), 32'(e_txd));
            chk("tx_busy", 32'(tx_busy), 32'(e_busy));
            chk("tx_done", 32'(tx_done), 32'(e_done));
            chk("rx_ready", 32'(rx_ready), reset ? 32'd0 : 32'(m_rdy));
            chk("rx_data", 32'(rx_data), reset ? 32'd0 : 32'(m_rxd));
            chk("rx_overrun", 32'(rx_overrun), reset ? 32'd0 : 32'(m_ovr));
            chk("rx_frame_err", 32'(rx_frame_err), reset ? 32'd0 : 32'(m_ferr));
        end
    end

    // Called just after a clock edge; the RX tick phase is fixed by the free-running divider since reset.
    task automatic send_rx(input logic [7:0] v, input bit stop_ok, input bit ack_c);
        logic [9:0] f;
        int s;
        f = {stop_ok, v, 1'b0};
        s = cyc + 3;
        while (((s - m_rel) % B) != 0) s++;
        ev_val = v; ev_ok = stop_ok; ev_edge = s + 8 * B + 144 * B; ev_pend = 1;
        for (int i = 0; i < FRAME; i++) begin
            rxd = f[i / BIT];
            rx_ack = ack_c && (cyc + 1 == ev_edge);
            @(posedge clk); #1;
        end
        rx_ack = 1'b0;
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        @(posedge clk); #1;
        rx_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk); #1;
        chk_en = 1;
        idle(2);
        reset = 1'b0;
        idle(1);
        chk("reset_txd", 32'(txd), 32'd1);
        chk("reset_tx_busy", 32'(tx_busy), 32'd0);
        chk("reset_rx_ready", 32'(rx_ready), 32'd0);
        chk("reset_rx_data", 32'(rx_data), 32'd0);

        // 0x55 frame with an ignored request mid-frame
        tx_data = 8'h55; tx_start = 1'b1;
        @(posedge clk); #1;
        acc = cyc; tx_start = 1'b0;
        done_n = -1; done_cnt = 0;
        for (int n = 1; n <= 340; n++) begin
            @(posedge clk); #1;
            tx_start = (n == 99);
            tx_data  = (n == 99) ? 8'hFF : 8'h55;
            if (n == 16) chk("tx55_start_bit", 32'(txd), 32'd0);
            if (n == 48) chk("tx55_bit0", 32'(txd), 32'd1);
            if (n == 80) chk("tx55_bit1", 32'(txd), 32'd0);
            if (tx_done) begin done_n = n; done_cnt++; end
        end
        chk("tx55_done_latency", 32'(done_n), 32'd320);
        chk("tx55_done_count", 32'(done_cnt), 32'd1);

        // Back-to-back TX frames in full duplex with an RX frame
        fork
            begin
                tx_data = 8'hC3; tx_start = 1'b1;
                @(posedge clk); #1;
                tx_start = 1'b0;
                got = 0;
                for (int n = 0; n < 400; n++) begin
                    @(negedge clk);
                    if (tx_done) begin got = 1; break; end
                end
                chk("txC3_done_seen", 32'(got), 32'd1);
                tx_data = 8'h3A; tx_start = 1'b1;
                @(posedge clk); #1;
                tx_start = 1'b0;
                got = 0;
                for (int n = 0; n < 400; n++) begin
                    @(negedge clk);
                    if (tx_done) begin got = 1; break; end
                end
                chk("tx3A_done_seen", 32'(got), 32'd1);
            end
            send_rx(8'hA5, 1'b1, 1'b0);
        join
        @(posedge clk); #1;
        chk("rxA5_data", 32'(rx_data), 32'hA5);
        chk("rxA5_ready", 32'(rx_ready), 32'd1);
        pulse_ack();
        chk("rxA5_ack_clears", 32'(rx_ready), 32'd0);

        // False start: 6 clocks low
        rxd = 1'b0; idle(6); rxd = 1'b1; idle(40);
        chk("false_start_ready", 32'(rx_ready), 32'd0);
        chk("false_start_err", 32'(rx_frame_err), 32'd0);

        // Framing error, break, then recovery
        send_rx(8'h3C, 1'b0, 1'b0);
        idle(64);
        chk("ferr_set", 32'(rx_frame_err), 32'd1);
        chk("ferr_no_ready", 32'(rx_ready), 32'd0);
        rxd = 1'b1; idle(20);
        send_rx(8'h5A, 1'b1, 1'b0);
        chk("after_break_data", 32'(rx_data), 32'h5A);
        chk("ferr_sticky", 32'(rx_frame_err), 32'd1);
        pulse_ack();

        // Overrun, then ack coinciding with completion
        send_rx(8'h11, 1'b1, 1'b0);
        send_rx(8'h22, 1'b1, 1'b0);
        chk("ovr_keeps_data", 32'(rx_data), 32'h11);
        chk("ovr_set", 32'(rx_overrun), 32'd1);
        pulse_ack();
        chk("ovr_cleared", 32'(rx_overrun), 32'd0);
        send_rx(8'h11, 1'b1, 1'b0);
        send_rx(8'h22, 1'b1, 1'b1);
        chk("coinc_data", 32'(rx_data), 32'h22);
        chk("coinc_ready", 32'(rx_ready), 32'd1);
        chk("coinc_no_ovr", 32'(rx_overrun), 32'd0);
        pulse_ack();

        // Reset during data bit 4 of a TX frame
        tx_data = 8'h96; tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
        idle(170);
        reset = 1'b1;
        #1;
        chk("midreset_txd", 32'(txd), 32'd1);
        chk("midreset_busy", 32'(tx_busy), 32'd0);
        idle(2);
        reset = 1'b0;
        done_cnt = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (tx_done) done_cnt++;
        end
        chk("midreset_no_done", 32'(done_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/pdp8_tt_uart.md
PDP8_TT_UART -- requirements
Module: pdp8_tt_uart

Interface
REQ-001 Parameter BAUD_DIV, default 326, clk cycles per 16x oversample tick (e.g. 50 MHz / (9600*16)); legal range 2..65535.
REQ-002 clk  input  1  system clock; all state changes on posedge clk.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 tx_data  input  8  character to transmit, sampled on accept.
REQ-005 tx_start  input  1  one-cycle request to send tx_data.
REQ-006 tx_busy  output  1  transmitter frame in progress.
REQ-007 tx_done  output  1  one-cycle pulse at end of stop bit; the TT IOT device uses it to set its printer flag/interrupt.
REQ-008 txd  output  1  serial out, idle high (mark).
REQ-009 rxd  input  1  serial in, asynchronous to clk.
REQ-010 rx_data  output  8  last received character.
REQ-011 rx_ready  output  1  level; rx_data holds an unread character (keyboard flag).
REQ-012 rx_ack  input  1  one-cycle pulse; consumer has read rx_data.
REQ-013 rx_overrun  output  1  sticky; character lost because rx_ready was still set.
REQ-014 rx_frame_err  output  1  sticky; stop bit sampled low.

Function
REQ-015 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, one stop bit 1.
REQ-016 Tick generator SHALL be a free-running counter 0..BAUD_DIV-1 emitting a one-cycle tick when the count equals BAUD_DIV-1; it is used only by RX.
REQ-017 TX FSM states SHALL be IDLE, START, DATA, STOP.
REQ-018 In IDLE, tx_start=1 SHALL latch tx_data, enter START, and set tx_busy at the next edge; txd goes low on the same edge.
REQ-019 tx_start while tx_busy=1 SHALL be ignored; the latched data SHALL NOT change.
REQ-020 TX SHALL use its own bit counter, cleared on accept; each bit lasts exactly 16*BAUD_DIV clocks, so a frame spans exactly 160*BAUD_DIV clocks from accept to the tx_done edge.
REQ-021 At end of STOP, tx_done SHALL pulse for one cycle, tx_busy SHALL clear in the same cycle, and the FSM returns to IDLE; a tx_start in the tx_done cycle SHALL be accepted (back-to-back frames, no idle gap).
REQ-022 rxd SHALL pass through a 2-flop synchronizer (reset value 1) before any use.
REQ-023 RX FSM states SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-024 IDLE->START on synchronized rxd=0 at a tick; START samples after 8 ticks: 1 -> IDLE (false start, no flag change), 0 -> DATA.
REQ-025 DATA SHALL sample every 16 ticks (bit centre), shifting LSB first, for 8 bits, then go to STOP.
REQ-026 STOP samples after 16 ticks: 1 -> character complete, go to IDLE; 0 -> set rx_frame_err, discard character, go to BREAK.
REQ-027 BREAK SHALL remain until synchronized rxd=1 at a tick, then go to IDLE.
REQ-028 On completion with rx_ready=0: load rx_data and set rx_ready.
REQ-029 On completion with rx_ready=1 and rx_ack=0: keep old rx_data and set rx_overrun.
REQ-030 rx_ack SHALL clear rx_ready, rx_overrun and rx_frame_err at the next edge.
REQ-031 If rx_ack coincides with completion, the new character SHALL be loaded, rx_ready stays 1, and rx_overrun is NOT set.
REQ-032 TX and RX SHALL operate fully independently, including full-duplex simultaneous frames.

Reset
REQ-033 Reset assertion SHALL immediately force txd=1 and all other outputs 0, both FSMs to IDLE, all counters to 0, and synchronizer flops to 1, including mid-frame.
REQ-034 After reset release, no tx_done and no rx_ready SHALL occur until a new tx_start or a new valid start bit.

Verification (BAUD_DIV=2, bit = 32 clocks)
REQ-035 tx_start with tx_data=0x55 -> txd = 0,1,0,1,0,1,0,1,0,1, each 32 clocks; tx_done pulses once 320 clocks after accept; tx_busy is high throughout.
REQ-036 Drive a 0xA5 frame on rxd -> rx_data=0xA5 and rx_ready=1 within 2 clocks after stop-bit centre + sync delay; rx_ack -> rx_ready=0.
REQ-037 rxd low for 6 clocks, then high -> no rx_ready, no error, RX back in IDLE.
REQ-038 Frame 0x3C with stop bit low -> rx_frame_err=1, rx_ready=0; RX waits in BREAK until rxd=1.
REQ-039 Two frames 0x11 then 0x22 with no rx_ack -> rx_data=0x11, rx_overrun=1; repeat with rx_ack in the completion cycle -> rx_data=0x22, rx_overrun=0.
REQ-040 Assert reset at bit 4 of a TX frame -> txd=1 and tx_busy=0 immediately; no tx_done follows.
